// File: rtl/ps2_device_model_if.sv
// Byte-level handshake between the system side and the PS/2 device model.
// The transmit path pushes scan-code bytes in; the receive path reports
// host command bytes out.
interface ps2_device_model_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  rx_error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output rx_error
  );
endinterface

// File: rtl/ps2_device_model.sv
// Device-side (keyboard end) PS/2 transceiver. Generates the PS/2 clock,
// sends queued bytes to the host and accepts host commands with ACK.
// Lines are open-collector: the *_pulldown outputs drive low when 1.
module ps2_device_model #(
  parameter int CLK_HALF_PERIOD = 3333,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic              main_clk,
  input  logic              reset,
  ps2_device_model_if.slave bus,
  output logic              busy,
  output logic              ps2_clock_pulldown,
  output logic              ps2_data_pulldown,
  input  logic              ps2_clock_in,
  input  logic              ps2_data_in
);
  localparam int H     = CLK_HALF_PERIOD;
  localparam int CW    = $clog2(2 * H + 1);
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  // Our own clock release needs two synchronizer cycles to be seen as high.
  localparam logic [CW-1:0] GUARD     = CW'(2);
  localparam logic [CW-1:0] HALF      = CW'(H);
  localparam logic [CW-1:0] LOW_LAST  = CW'(H - 1);
  localparam logic [CW-1:0] PULSE_AT  = CW'(2 * H - 2);
  localparam logic [CW-1:0] CELL_LAST = CW'(2 * H - 1);
  localparam logic [CW-1:0] IDLE_MIN  = CW'(2 * H);
  localparam logic [AW:0]   FULL_CNT  = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TX_BIT = 3'd1,
    ST_RX_BIT = 3'd2,
    ST_RX_ACK = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // True when data ones plus the parity bit form an odd count.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_t        state_q;
  logic [CW-1:0] cnt_q, idle_cnt_q;
  logic [3:0]    bit_q, bit_nxt_s;
  logic          clk_pd_q, dat_pd_q, busy_q;
  logic [7:0]    rx_shift_q, rx_data_q;
  logic          rx_par_q, rx_stop_q, rx_valid_q, rx_error_q;
  logic          push_s, pop_s, tx_ready_s;
  logic [7:0]    head_s;
  logic [10:0]   tx_frame_s;

  assign tx_ready_s = (count_q != FULL_CNT);
  assign push_s     = bus.tx_valid && tx_ready_s;
  assign pop_s      = (state_q == ST_TX_BIT) && (bit_q == 4'd10) && (cnt_q == CELL_LAST);
  assign head_s     = mem_q[rd_ptr_q];
  assign tx_frame_s = {1'b1, ~(^head_s), head_s, 1'b0};
  assign bit_nxt_s  = bit_q + 4'd1;

  assign bus.tx_ready        = tx_ready_s;
  assign bus.rx_data         = rx_data_q;
  assign bus.rx_valid        = rx_valid_q;
  assign bus.rx_error        = rx_error_q;
  assign busy                = busy_q;
  assign ps2_clock_pulldown  = clk_pd_q;
  assign ps2_data_pulldown   = dat_pd_q;

  // Two-flop synchronizers for the asynchronous line inputs (idle lines read high).
  always_ff @(posedge main_clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clock_in;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  // FIFO occupancy next state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge main_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  // FIFO pointers wrap naturally modulo the depth.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      count_q <= count_d;
    end
  end

  // Protocol FSM with registered line drivers and receive outputs.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      idle_cnt_q <= '0;
      clk_pd_q   <= 1'b0;
      dat_pd_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_shift_q <= 8'h00;
      rx_par_q   <= 1'b0;
      rx_stop_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q    <= '0;
          bit_q    <= 4'd0;
          clk_pd_q <= 1'b0;
          dat_pd_q <= 1'b0;
          if (clk_sync_q && dat_sync_q) begin
            if (idle_cnt_q < IDLE_MIN) idle_cnt_q <= idle_cnt_q + CNT_ONE;
          end else begin
            idle_cnt_q <= '0;
          end
          if (clk_sync_q && !dat_sync_q && !clk_pd_q && !dat_pd_q) begin
            // Host request: start bit already on the line, clock cell 0 low now.
            state_q    <= ST_RX_BIT;
            busy_q     <= 1'b1;
            clk_pd_q   <= 1'b1;
            idle_cnt_q <= '0;
          end else if (clk_sync_q && (count_q != '0) && (idle_cnt_q >= IDLE_MIN)) begin
            state_q    <= ST_TX_BIT;
            busy_q     <= 1'b1;
            dat_pd_q   <= ~tx_frame_s[0];
            idle_cnt_q <= '0;
          end
        end
        ST_TX_BIT: begin
          if ((bit_q < 4'd10) && (cnt_q >= GUARD) && (cnt_q < HALF) && !clk_sync_q) begin
            // Host pulled the clock while we released it: abort, byte stays queued.
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            clk_pd_q <= 1'b0;
            dat_pd_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
          end else if (cnt_q == CELL_LAST) begin
            cnt_q    <= '0;
            clk_pd_q <= 1'b0;
            if (bit_q == 4'd10) begin
              state_q  <= ST_GAP;
              dat_pd_q <= 1'b0;
            end else begin
              bit_q    <= bit_nxt_s;
              dat_pd_q <= ~tx_frame_s[bit_nxt_s];
            end
          end else begin
            cnt_q    <= cnt_q + CNT_ONE;
            clk_pd_q <= (cnt_q >= LOW_LAST);
          end
        end
        ST_RX_BIT: begin
          dat_pd_q <= 1'b0;
          if (cnt_q == LOW_LAST) begin
            if (bit_q < 4'd8)       rx_shift_q <= {dat_sync_q, rx_shift_q[7:1]};
            else if (bit_q == 4'd8) rx_par_q   <= dat_sync_q;
            else                    rx_stop_q  <= dat_sync_q;
          end
          if (cnt_q == CELL_LAST) begin
            cnt_q <= '0;
            if (bit_q == 4'd9) begin
              // ACK cell is only clocked and driven when the stop bit was good.
              state_q  <= ST_RX_ACK;
              bit_q    <= 4'd0;
              clk_pd_q <= rx_stop_q;
              dat_pd_q <= rx_stop_q;
            end else begin
              bit_q    <= bit_nxt_s;
              clk_pd_q <= 1'b1;
            end
          end else begin
            cnt_q    <= cnt_q + CNT_ONE;
            clk_pd_q <= (cnt_q < LOW_LAST);
          end
        end
        ST_RX_ACK: begin
          if (cnt_q == PULSE_AT) begin
            rx_valid_q <= 1'b1;
            rx_error_q <= ~odd_parity_ok(rx_shift_q, rx_par_q) | ~rx_stop_q;
            if (rx_stop_q) rx_data_q <= rx_shift_q;
          end
          if (cnt_q == CELL_LAST) begin
            state_q  <= ST_GAP;
            cnt_q    <= '0;
            clk_pd_q <= 1'b0;
            dat_pd_q <= 1'b0;
          end else begin
            cnt_q    <= cnt_q + CNT_ONE;
            clk_pd_q <= rx_stop_q && (cnt_q < LOW_LAST);
            dat_pd_q <= rx_stop_q;
          end
        end
        ST_GAP: begin
          clk_pd_q <= 1'b0;
          dat_pd_q <= 1'b0;
          if (cnt_q == CELL_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          clk_pd_q <= 1'b0;
          dat_pd_q <= 1'b0;
          cnt_q    <= '0;
          bit_q    <= 4'd0;
        end
      endcase
    end
  end
endmodule
